// File: rtl/accelerator_pkg.sv
// Shared encodings for the vector accelerator interface: RVV opcode fields,
// dispatcher FSM states and the scalar-writeback decode helper.
package accelerator_pkg;

  localparam logic [6:0] V_MAJOR_OP_V       = 7'b1010111;
  localparam logic [2:0] V_OPCFG            = 3'b111;
  localparam logic [2:0] V_OPMVV            = 3'b010;
  localparam logic [5:0] V_FUNCT6_VWXUNARY0 = 6'b010000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } apu_disp_state_t;

  // Only vsetvl{i} (OPCFG) and vmv.x.s (VWXUNARY0 under OPMVV) return a scalar.
  function automatic logic has_scalar_wb(input logic [31:0] instr);
    logic is_v;
    is_v = (instr[6:0] == V_MAJOR_OP_V);
    return is_v && ((instr[14:12] == V_OPCFG) ||
                    ((instr[14:12] == V_OPMVV) && (instr[31:26] == V_FUNCT6_VWXUNARY0)));
  endfunction

endpackage

// File: rtl/apu_dispatcher.sv
// Single-outstanding APU initiator: latches an issued vector instruction, drives
// req/gnt to the accelerator, waits for rvalid and returns an optional scalar writeback.
module apu_dispatcher
  import accelerator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  input  logic [14:0]      flags_i,
  output logic             apu_req,
  output logic [2:0][31:0] apu_operands,
  output logic [5:0]       apu_op,
  output logic [14:0]      apu_flags_o,
  input  logic             apu_gnt,
  input  logic             apu_rvalid,
  input  logic [31:0]      apu_result,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic             busy_o,
  output logic             err_timeout_o,
  output logic             err_spurious_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               WDOG_ON  = (TIMEOUT_CYCLES != 0);

  apu_disp_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic             wb_en;

  assign instr_ready_o = n_reset && (state == IDLE);
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      wb_en          <= 1'b0;
      apu_req        <= 1'b0;
      apu_operands   <= '0;
      apu_op         <= '0;
      apu_flags_o    <= '0;
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      err_timeout_o  <= 1'b0;
      err_spurious_o <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      err_timeout_o  <= 1'b0;
      err_spurious_o <= apu_rvalid && (state != RESP);

      case (state)
        IDLE: begin
          if (instr_valid_i) begin
            apu_operands[0] <= rs1_data_i;
            apu_operands[1] <= rs2_data_i;
            apu_operands[2] <= instr_i;
            apu_op          <= instr_i[31:26];
            apu_flags_o     <= flags_i;
            wb_en           <= has_scalar_wb(instr_i);
            apu_req         <= 1'b1;
            state           <= REQ;
          end
        end

        REQ: begin
          if (apu_gnt) begin
            apu_req <= 1'b0;
            cnt     <= '0;
            state   <= RESP;
          end
        end

        RESP: begin
          // A response arriving on the last watchdog cycle still completes normally.
          if (apu_rvalid) begin
            state <= IDLE;
            if (wb_en) begin
              wb_valid_o <= 1'b1;
              wb_rd_o    <= apu_operands[2][11:7];
              wb_data_o  <= apu_result;
            end
          end else if (WDOG_ON && (cnt == CNT_LAST)) begin
            err_timeout_o <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_dispatcher.sv
// Directed bench for apu_dispatcher with a 4-cycle watchdog; cycle k starts at posedge k.
module tb_apu_dispatcher;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instr_i;
  logic [31:0]      rs1_data_i;
  logic [31:0]      rs2_data_i;
  logic [14:0]      flags_i;
  logic             apu_req;
  logic [2:0][31:0] apu_operands;
  logic [5:0]       apu_op;
  logic [14:0]      apu_flags_o;
  logic             apu_gnt;
  logic             apu_rvalid;
  logic [31:0]      apu_result;
  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;
  logic             busy_o;
  logic             err_timeout_o;
  logic             err_spurious_o;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] VSETVLI_RD5 = 32'h0000F2D7;
  localparam logic [31:0] VSETVLI_RD7 = 32'h0000F3D7;
  localparam logic [31:0] VADD_VV     = 32'h022081D7;
  localparam logic [31:0] VMV_X_S     = 32'h42402557;

  apu_dispatcher #(.TIMEOUT_CYCLES(4), .CNT_W(9)) dut (
    .clk(clk), .n_reset(n_reset),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flags_i(flags_i),
    .apu_req(apu_req), .apu_operands(apu_operands), .apu_op(apu_op), .apu_flags_o(apu_flags_o),
    .apu_gnt(apu_gnt), .apu_rvalid(apu_rvalid), .apu_result(apu_result),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_spurious_o(err_spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [14:0] flg);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    rs1_data_i    = rs1;
    rs2_data_i    = rs2;
    flags_i       = flg;
  endtask

  initial begin
    n_reset       = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    rs1_data_i    = '0;
    rs2_data_i    = '0;
    flags_i       = '0;
    apu_gnt       = 1'b0;
    apu_rvalid    = 1'b0;
    apu_result    = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", instr_ready_o, 0);
    chk("rst_req", apu_req, 0);
    chk("rst_operands", apu_operands, 0);
    chk("rst_op", apu_op, 0);
    chk("rst_flags", apu_flags_o, 0);
    chk("rst_wb", {wb_valid_o, wb_rd_o, wb_data_o}, 0);
    chk("rst_busy_err", {busy_o, err_timeout_o, err_spurious_o}, 0);
    n_reset = 1'b1;
    #1;
    chk("rst_release_ready", instr_ready_o, 1);

    // vsetvli rd=5, rs1=8: accept c0, gnt c1, rvalid c4 -> wb c5
    tick();
    present(VSETVLI_RD5, 32'd8, 32'd3, 15'h1234);
    chk("t1_ready_c0", instr_ready_o, 1);
    tick();
    instr_valid_i = 1'b0;
    chk("t1_req_c1", apu_req, 1);
    chk("t1_opnds_c1", apu_operands, {VSETVLI_RD5, 32'd3, 32'd8});
    chk("t1_op_flags_c1", {apu_op, apu_flags_o}, {6'd0, 15'h1234});
    chk("t1_busy_c1", {busy_o, instr_ready_o}, 2'b10);
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    chk("t1_req_c2", apu_req, 0);
    tick();
    tick();
    apu_rvalid = 1'b1;
    apu_result = 32'd8;
    chk("t1_nowb_c4", wb_valid_o, 0);
    tick();
    apu_rvalid = 1'b0;
    chk("t1_wb_c5", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd5, 32'd8});
    chk("t1_ready_c5", {instr_ready_o, busy_o}, 2'b10);
    tick();
    chk("t1_wb_pulse_c6", wb_valid_o, 0);

    // vadd.vv with gnt low for 3 cycles; no writeback
    present(VADD_VV, 32'hA5A5_0001, 32'h5A5A_0002, 15'h0F0F);
    for (int c = 1; c <= 4; c++) begin
      tick();
      instr_valid_i = 1'b0;
      instr_i       = 32'hFFFF_FFFF;
      rs1_data_i    = 32'hFFFF_FFFF;
      chk($sformatf("t2_req_c%0d", c), apu_req, 1);
      chk($sformatf("t2_opnds_c%0d", c), apu_operands, {VADD_VV, 32'h5A5A_0002, 32'hA5A5_0001});
      if (c == 4) apu_gnt = 1'b1;
    end
    tick();
    apu_gnt = 1'b0;
    chk("t2_req_c5", apu_req, 0);
    apu_rvalid = 1'b1;
    apu_result = 32'h1111_2222;
    tick();
    apu_rvalid = 1'b0;
    chk("t2_nowb", wb_valid_o, 0);
    chk("t2_idle", {instr_ready_o, busy_o, err_timeout_o}, 3'b100);

    // vmv.x.s rd=10 returns DEADBEEF
    present(VMV_X_S, 32'd0, 32'd0, 15'h0);
    tick();
    instr_valid_i = 1'b0;
    chk("t3_op", apu_op, 6'b010000);
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    apu_rvalid = 1'b1;
    apu_result = 32'hDEADBEEF;
    tick();
    apu_rvalid = 1'b0;
    chk("t3_wb", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd10, 32'hDEADBEEF});

    // Watchdog: gnt at c1, no rvalid -> err_timeout at c6
    present(VADD_VV, 32'd1, 32'd2, 15'h0);
    tick();
    instr_valid_i = 1'b0;
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("t4_noerr_c%0d", c), {err_timeout_o, busy_o}, 2'b01);
      tick();
    end
    chk("t4_err_c6", {err_timeout_o, busy_o, wb_valid_o, instr_ready_o}, 4'b1001);
    tick();
    chk("t4_err_pulse_c7", err_timeout_o, 0);

    // rvalid on the 4th RESP cycle wins over the watchdog
    present(VSETVLI_RD5, 32'd16, 32'd0, 15'h0);
    tick();
    instr_valid_i = 1'b0;
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    tick();
    tick();
    tick();
    apu_rvalid = 1'b1;
    apu_result = 32'd16;
    tick();
    apu_rvalid = 1'b0;
    chk("t5_wb", {wb_valid_o, wb_rd_o, wb_data_o, err_timeout_o}, {1'b1, 5'd5, 32'd16, 1'b0});
    tick();
    chk("t5_no_late_err", err_timeout_o, 0);

    // Spurious rvalid in IDLE
    apu_rvalid = 1'b1;
    tick();
    apu_rvalid = 1'b0;
    chk("t6_spurious", {err_spurious_o, busy_o, instr_ready_o, wb_valid_o}, 4'b1010);
    tick();
    chk("t6_spurious_pulse", err_spurious_o, 0);

    // Reset dropped during RESP
    present(VSETVLI_RD5, 32'd4, 32'd0, 15'h7);
    tick();
    instr_valid_i = 1'b0;
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    chk("t7_in_resp", busy_o, 1);
    n_reset = 1'b0;
    #1;
    chk("t7_rst_now", {apu_req, busy_o, instr_ready_o}, 3'b000);
    chk("t7_rst_operands", apu_operands, 0);
    tick();
    n_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t7_nowb_%0d", c), {wb_valid_o, err_timeout_o, err_spurious_o, busy_o}, 4'b0);
    end

    // Back-to-back vsetvli with instr_valid held
    present(VSETVLI_RD5, 32'd1, 32'd0, 15'h0);
    tick();
    instr_i = VSETVLI_RD7;
    chk("t8_hold_ready_c1", instr_ready_o, 0);
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    tick();
    chk("t8_first_kept", apu_operands[2], VSETVLI_RD5);
    apu_rvalid = 1'b1;
    apu_result = 32'h11;
    tick();
    apu_rvalid = 1'b0;
    chk("t8_wb1", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd5, 32'h11});
    chk("t8_ready_c4", instr_ready_o, 1);
    tick();
    instr_valid_i = 1'b0;
    chk("t8_second_acc", {apu_req, apu_operands[2]}, {1'b1, VSETVLI_RD7});
    apu_gnt = 1'b1;
    tick();
    apu_gnt = 1'b0;
    apu_rvalid = 1'b1;
    apu_result = 32'h22;
    tick();
    apu_rvalid = 1'b0;
    chk("t8_wb2", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd7, 32'h22});
    tick();
    chk("t8_hold_after", {apu_operands[2], apu_op, busy_o}, {VSETVLI_RD7, 6'd0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
